// File: rtl/packet_echo_buffer.sv
// Packet echo buffer: queues received packets in a circular FIFO and launches them, optionally
// transformed, to a downstream sender using a launch-pulse / busy handshake.
module packet_echo_buffer #(
    parameter int unsigned PACKET_SIZE = 4,
    parameter int unsigned DEPTH       = 4,
    localparam int unsigned AW         = $clog2(DEPTH),
    localparam int unsigned PW         = 8 * PACKET_SIZE
) (
    input  logic          hwclk,
    input  logic          rst,
    input  logic [PW-1:0] rx_packet,
    input  logic          rx_ready,
    input  logic [1:0]    mode,
    input  logic          tx_busy,
    output logic [PW-1:0] tx_packet,
    output logic          tx_enable,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    drop_count,
    output logic          led
);

    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWaitHi,
        StWaitLo
    } state_e;

    state_e        state_q;
    logic [PW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [1:0]    wait_q;

    logic not_empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    function automatic logic [PW-1:0] transform(input logic [PW-1:0] d, input logic [1:0] m);
        logic [PW-1:0] r;
        r = d;
        case (m)
            2'd1: begin
                for (int i = 0; i < int'(PACKET_SIZE); i++) begin
                    r[8*i +: 8] = d[8*(int'(PACKET_SIZE) - 1 - i) +: 8];
                end
            end
            2'd2:    r = ~d;
            default: r = d;
        endcase
        return r;
    endfunction

    // A pop frees a slot in the same cycle, so a full FIFO can still accept while launching.
    always_comb begin
        not_empty = (count != '0);
        full      = (count == FullCount);
        pop       = (state_q == StIdle) && not_empty && !tx_busy;
        push      = rx_ready && (!full || pop);
        drop      = rx_ready && !push;
    end

    always_ff @(posedge hwclk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wait_q     <= '0;
            count      <= '0;
            tx_packet  <= '0;
            tx_enable  <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
            led        <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= rx_packet;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end

            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end

            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end

            tx_enable <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        tx_packet <= transform(mem_q[rd_ptr_q], mode);
                        tx_enable <= 1'b1;
                        led       <= ~led;
                        state_q   <= StLaunch;
                    end
                end
                StLaunch: begin
                    wait_q  <= '0;
                    state_q <= StWaitHi;
                end
                // Give the sender four cycles to raise busy; otherwise treat the packet as sent.
                StWaitHi: begin
                    if (tx_busy) begin
                        state_q <= StWaitLo;
                    end else if (wait_q == 2'd3) begin
                        state_q <= StIdle;
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                StWaitLo: begin
                    if (!tx_busy) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_echo_buffer.sv
// Directed scoreboard bench for packet_echo_buffer (PACKET_SIZE=4, DEPTH=4).
module tb_packet_echo_buffer;

    localparam int unsigned PW = 32;
    localparam int unsigned AW = 2;

    logic          hwclk = 1'b0;
    logic          rst;
    logic [PW-1:0] rx_packet;
    logic          rx_ready;
    logic [1:0]    mode;
    logic          tx_busy;
    logic [PW-1:0] tx_packet;
    logic          tx_enable;
    logic [AW:0]   count;
    logic          overflow;
    logic [7:0]    drop_count;
    logic          led;

    int            n_cmp = 0;
    int            n_err = 0;
    int            n_launch = 0;
    logic [PW-1:0] sb [$];
    logic          led_exp = 1'b0;
    logic          prev_en = 1'b0;
    logic [PW-1:0] last_exp = '0;

    packet_echo_buffer #(
        .PACKET_SIZE(4),
        .DEPTH      (4)
    ) dut (
        .hwclk     (hwclk),
        .rst       (rst),
        .rx_packet (rx_packet),
        .rx_ready  (rx_ready),
        .mode      (mode),
        .tx_busy   (tx_busy),
        .tx_packet (tx_packet),
        .tx_enable (tx_enable),
        .count     (count),
        .overflow  (overflow),
        .drop_count(drop_count),
        .led       (led)
    );

    always #5 hwclk = ~hwclk;

    function automatic logic [PW-1:0] model(input logic [PW-1:0] d, input logic [1:0] m);
        case (m)
            2'd1:    return {d[7:0], d[15:8], d[23:16], d[31:24]};
            2'd2:    return ~d;
            default: return d;
        endcase
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; any launch seen is checked against the scoreboard head.
    task automatic tick();
        logic [PW-1:0] exp;
        @(posedge hwclk);
        #1;
        if (tx_enable === 1'b1) begin
            n_launch++;
            check("single_cycle_enable", prev_en, 1'b0);
            check("launch_expected", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                exp      = sb.pop_front();
                last_exp = exp;
                check("tx_packet", tx_packet, exp);
            end
            led_exp = ~led_exp;
            check("led_toggle", led, led_exp);
        end
        prev_en = tx_enable;
    endtask

    task automatic send(input logic [PW-1:0] pkt, input logic [1:0] m, input bit accept);
        mode      = m;
        rx_packet = pkt;
        rx_ready  = 1'b1;
        if (accept) sb.push_back(model(pkt, m));
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic wait_launch(input int bound, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (tx_enable !== 1'b1 && cycles < bound);
        if (tx_enable !== 1'b1) check("launch_timeout", tx_enable, 1'b1);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (sb.size() > 0 && n < bound) begin
            tick();
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int cyc;
        int launches_before;

        rst       = 1'b1;
        rx_ready  = 1'b0;
        rx_packet = '0;
        mode      = 2'd0;
        tx_busy   = 1'b0;
        tick();
        tick();
        check("rst_tx_enable", tx_enable, 1'b0);
        check("rst_tx_packet", tx_packet, 32'h0);
        check("rst_count", count, 3'd0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_drop_count", drop_count, 8'd0);
        check("rst_led", led, 1'b0);
        rst = 1'b0;
        tick();

        // Single echo: launch exactly two cycles after rx_ready.
        send(32'h44332211, 2'd0, 1'b1);
        check("count_after_push", count, 3'd1);
        tick();
        check("latency_c_plus_2", tx_enable, 1'b1);
        check("led_first", led, 1'b1);
        check("count_after_pop", count, 3'd0);

        // Queued packet waits out the WAIT_HI timeout: next launch six cycles later.
        send(32'hA5A5_0F0F, 2'd0, 1'b1);
        wait_launch(20, cyc);
        check("timeout_relaunch_gap", cyc, 5);
        repeat (6) tick();

        send(32'h44332211, 2'd1, 1'b1);
        wait_launch(10, cyc);
        check("mode1_reverse", tx_packet, 32'h11223344);
        repeat (6) tick();

        send(32'h44332211, 2'd2, 1'b1);
        wait_launch(10, cyc);
        check("mode2_invert", tx_packet, 32'hBBCCDDEE);
        repeat (6) tick();

        // Mode 3 passes through; second push coincides with first pop.
        send(32'hDEAD_BEEF, 2'd3, 1'b1);
        send(32'h1234_5678, 2'd3, 1'b1);
        check("push_pop_count", count, 3'd1);
        check("push_pop_launch", tx_enable, 1'b1);
        drain(20);
        repeat (6) tick();

        // Burst with sender busy: four stored, two dropped.
        tx_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(32'hC000_0000 + 32'(i), 2'd0, i < 4);
        end
        check("burst_count", count, 3'd4);
        check("burst_overflow", overflow, 1'b1);
        check("burst_drop_count", drop_count, 8'd2);
        check("tx_packet_hold", tx_packet, last_exp);
        tx_busy = 1'b0;
        drain(60);
        repeat (6) tick();

        // Full FIFO accepts a packet in the same cycle as a pop.
        tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(32'h5000_0000 + 32'(i), 2'd0, 1'b1);
        end
        check("full_count", count, 3'd4);
        tx_busy = 1'b0;
        send(32'h5000_00FF, 2'd0, 1'b1);
        check("full_pop_count", count, 3'd4);
        check("full_pop_drop_count", drop_count, 8'd2);
        check("full_pop_launch", tx_enable, 1'b1);
        // Sender handshake through WAIT_LO.
        tx_busy = 1'b1;
        tick();
        tick();
        tick();
        tx_busy = 1'b0;
        wait_launch(10, cyc);
        check("wait_lo_relaunch_gap", cyc, 2);
        drain(60);
        repeat (6) tick();

        // Reset during WAIT_LO with three packets buffered; rst beats rx_ready.
        tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(32'h7000_0000 + 32'(i), 2'd0, 1'b1);
        end
        tx_busy = 1'b0;
        tick();
        check("pre_reset_launch", tx_enable, 1'b1);
        tx_busy = 1'b1;
        tick();
        tick();
        check("pre_reset_count", count, 3'd3);
        rst       = 1'b1;
        rx_ready  = 1'b1;
        rx_packet = 32'hFFFF_FFFF;
        tick();
        rst      = 1'b0;
        rx_ready = 1'b0;
        sb.delete();
        led_exp = 1'b0;
        check("mid_rst_count", count, 3'd0);
        check("mid_rst_tx_enable", tx_enable, 1'b0);
        check("mid_rst_led", led, 1'b0);
        check("mid_rst_overflow", overflow, 1'b0);
        check("mid_rst_drop_count", drop_count, 8'd0);
        tx_busy = 1'b0;
        launches_before = n_launch;
        repeat (12) tick();
        check("no_launch_after_reset", n_launch - launches_before, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
